branch_pred_flush_ctrl: RTL and testbench

Branch-prediction and control-hazard controller for the 5-stage MIPS pipeline.
- Holds a 2-bit saturating-counter branch history table (BHT) and supplies the IF-stage taken/not-taken prediction.
- Resolves branches and jumps arriving in MEM, then trains the BHT.
- Sequences a multi-cycle flush of IF/ID/EX with a PC redirect on mispredict or jump, ignoring wrong-path MEM events while a flush is in progress.

---
 rtl/branch_pred_flush_ctrl.sv | 150 +++++++++++++++
 tb/tb_branch_pred_flush_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_flush_ctrl.sv
// branch_pred_flush_ctrl
//   Branch prediction and control-hazard controller for the 5-stage MIPS
//   pipeline. It holds a 2-bit saturating-counter branch history table
//   (BHT) that supplies the IF-stage prediction. It resolves branches and
//   jumps in MEM and trains the BHT. On a mispredict or a jump it flushes
//   IF/ID/EX for FLUSH_CYC cycles and issues a PC redirect. MEM events that
//   arrive while a flush is in progress are wrong-path and are ignored.
//
// Parameters
//   IDX_W      BHT index width (2^IDX_W entries, index = pc[IDX_W+1:2])
//   FLUSH_CYC  cycles flush stays high per event (>= 1)
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   if_pc             PC in IF; pred_taken is its combinational prediction
//   mem_*             resolved instruction in MEM (valid, type, outcome,
//                     carried prediction, pc, target)
//   flush             squash IF/ID/EX pipeline registers
//   redirect_valid    one-cycle pulse: load redirect_pc into the PC
//   redirect_pc       corrected fetch address
//   busy              high while the FSM is in FLUSH
//
// Optional feature (macro BRANCH_PRED_STATS_EN)
//   Adds 32-bit wrapping outputs br_count (qualified branches) and
//   mispred_count (qualified mispredicts; jumps are not counted).

module branch_pred_flush_ctrl #(
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned FLUSH_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        mem_valid,
    input  logic        mem_is_branch,
    input  logic        mem_is_jump,
    input  logic        mem_taken,
    input  logic        mem_pred,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_target,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
`endif
);

    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [1:0]       bht [DEPTH];
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             idle;
    logic             jump_ev;
    logic             br_ev;
    logic             mispred;
    logic             start_flush;
    logic [1:0]       cur_ctr;
    logic [1:0]       nxt_ctr;
    logic [31:0]      tgt;

    // Only the index bits of the PCs are meaningful to the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    assign if_idx     = if_pc[IDX_W+1:2];
    assign mem_idx    = mem_pc[IDX_W+1:2];
    assign pred_taken = bht[if_idx][1];

    assign flush = (state == ST_FLUSH);
    assign busy  = (state == ST_FLUSH);

    always_comb begin
        idle        = (state == ST_IDLE);
        jump_ev     = idle & mem_valid & mem_is_jump;
        br_ev       = idle & mem_valid & mem_is_branch & ~mem_is_jump;
        mispred     = br_ev & (mem_taken != mem_pred);
        start_flush = jump_ev | mispred;

        cur_ctr = bht[mem_idx];
        nxt_ctr = cur_ctr;
        if (mem_taken) begin
            if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
        end else begin
            if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
        end

        // A jump always redirects to its target; a mispredicted branch
        // goes to the target if taken, otherwise to the fall-through.
        tgt = (jump_ev | mem_taken) ? mem_target : mem_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
        end else if (br_ev) begin
            bht[mem_idx] <= nxt_ctr;
        end
    end

    // The counter is loaded with FLUSH_CYC-1 on entry, and FLUSH exits on
    // the edge where it reads zero. This keeps flush high for exactly
    // FLUSH_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (start_flush) begin
                    state          <= ST_FLUSH;
                    cnt            <= CNT_W'(FLUSH_CYC - 1);
                    redirect_valid <= 1'b1;
                    redirect_pc    <= tgt;
                end
            end else begin
                if (cnt == '0) state <= ST_IDLE;
                else           cnt   <= cnt - 1'b1;
            end
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (br_ev)   br_count      <= br_count + 32'd1;
            if (mispred) mispred_count <= mispred_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_pred_flush_ctrl.sv
module tb_branch_pred_flush_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        mem_valid;
    logic        mem_is_branch;
    logic        mem_is_jump;
    logic        mem_taken;
    logic        mem_pred;
    logic [31:0] mem_pc;
    logic [31:0] mem_target;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] br_count;
    logic [31:0] mispred_count;
    int unsigned exp_br;
    int unsigned exp_mis;
`endif

    int n_cmp;
    int n_bad;

    branch_pred_flush_ctrl #(
        .IDX_W    (6),
        .FLUSH_CYC(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .mem_valid     (mem_valid),
        .mem_is_branch (mem_is_branch),
        .mem_is_jump   (mem_is_jump),
        .mem_taken     (mem_taken),
        .mem_pred      (mem_pred),
        .mem_pc        (mem_pc),
        .mem_target    (mem_target),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .busy          (busy)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .br_count      (br_count),
        .mispred_count (mispred_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_mem(input logic br, input logic jmp, input logic tk,
                             input logic pr, input logic [31:0] pc,
                             input logic [31:0] tg);
        mem_valid     = 1'b1;
        mem_is_branch = br;
        mem_is_jump   = jmp;
        mem_taken     = tk;
        mem_pred      = pr;
        mem_pc        = pc;
        mem_target    = tg;
    endtask

    task automatic idle_mem();
        mem_valid     = 1'b0;
        mem_is_branch = 1'b0;
        mem_is_jump   = 1'b0;
        mem_taken     = 1'b0;
        mem_pred      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_pc = 32'h0;
        mem_pc = 32'h0;
        mem_target = 32'h0;
        idle_mem();
        #12;
        n_cmp++;
        if ({flush, redirect_valid, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got f/rv/b=%b required 000", {flush, redirect_valid, busy});
        end
        n_cmp++;
        if (redirect_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rpc: got %h required 00000000", redirect_pc);
        end
        for (int i = 0; i < 3; i++) begin
            if_pc = (i == 0) ? 32'h00 : (i == 1) ? 32'h40 : 32'hFC;
            #1;
            n_cmp++;
            if (pred_taken !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_pred pc=%h: got %b required 0", if_pc, pred_taken);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
`ifdef BRANCH_PRED_STATS_EN
        exp_br = 0;
        exp_mis = 0;
        n_cmp++;
        if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_stats: got %0d/%0d required 0/0", br_count, mispred_count);
        end
`endif
    endtask

    task automatic test_mispredict_taken();
        drive_mem(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h100);
        if_pc = 32'h40;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL same_cycle_read: got %b required 0", pred_taken);
        end
        step();
        idle_mem();
        n_cmp++;
        if ({flush, redirect_valid, busy} !== 3'b111 || redirect_pc !== 32'h100) begin
            n_bad++;
            $display("FAIL mis_c1: got f/rv/b=%b rpc=%h required 111 00000100",
                     {flush, redirect_valid, busy}, redirect_pc);
        end
        step();
        n_cmp++;
        if ({flush, redirect_valid, busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL mis_c2: got f/rv/b=%b required 101", {flush, redirect_valid, busy});
        end
        step();
        n_cmp++;
        if ({flush, redirect_valid, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL mis_c3: got f/rv/b=%b required 000", {flush, redirect_valid, busy});
        end
        n_cmp++;
        if (pred_taken !== 1'b1) begin
            n_bad++;
            $display("FAIL mis_trained: got %b required 1", pred_taken);
        end
`ifdef BRANCH_PRED_STATS_EN
        exp_br++;
        exp_mis++;
`endif
    endtask

    task automatic test_saturation();
        // Entry for 0x40 is 10 here; three correct taken branches saturate it.
        for (int i = 0; i < 3; i++) begin
            drive_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h100);
            step();
            n_cmp++;
            if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL sat_noflush[%0d]: got f/rv=%b%b required 00", i, flush, redirect_valid);
            end
        end
        // Not-taken while predicted taken: 11 -> 10, still predicts taken.
        drive_mem(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100);
        step();
        idle_mem();
        n_cmp++;
        if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h44) begin
            n_bad++;
            $display("FAIL sat_mis: got f/rv=%b%b rpc=%h required 11 00000044",
                     flush, redirect_valid, redirect_pc);
        end
        if_pc = 32'h40;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_entry10: got %b required 1", pred_taken);
        end
        step();
        step();
        // If 11 had not saturated, a fourth taken would make the counter read 11
        // and one down-step would still leave 10. Probe once more to check that
        // a second not-taken drops it to weak not-taken (01 -> 0).
        drive_mem(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100);
        step();
        idle_mem();
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_down2: got %b required 0", pred_taken);
        end
        step();
        step();
`ifdef BRANCH_PRED_STATS_EN
        exp_br += 5;
        exp_mis += 2;
`endif
    endtask

    task automatic test_jump();
        drive_mem(1'b1, 1'b1, 1'b1, 1'b0, 32'h60, 32'h2000);
        step();
        idle_mem();
        n_cmp++;
        if ({flush, redirect_valid, busy} !== 3'b111 || redirect_pc !== 32'h2000) begin
            n_bad++;
            $display("FAIL jump_c1: got f/rv/b=%b rpc=%h required 111 00002000",
                     {flush, redirect_valid, busy}, redirect_pc);
        end
        step();
        step();
        n_cmp++;
        if (flush !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_end: got flush=%b required 0", flush);
        end
        if_pc = 32'h60;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_notrain: got %b required 0", pred_taken);
        end
    endtask

    task automatic test_wrong_path();
        drive_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h3000);
        step();
        n_cmp++;
        if (busy !== 1'b1 || redirect_pc !== 32'h3000) begin
            n_bad++;
            $display("FAIL wp_enter: got busy=%b rpc=%h required 1 00003000", busy, redirect_pc);
        end
        drive_mem(1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h900);
        step();
        n_cmp++;
        if (redirect_valid !== 1'b0 || flush !== 1'b1) begin
            n_bad++;
            $display("FAIL wp_c2: got rv=%b f=%b required 0 1", redirect_valid, flush);
        end
        step();
        idle_mem();
        n_cmp++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h3000) begin
            n_bad++;
            $display("FAIL wp_c3: got rv=%b f=%b rpc=%h required 0 0 00003000",
                     redirect_valid, flush, redirect_pc);
        end
        if_pc = 32'h80;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL wp_notrain: got %b required 0", pred_taken);
        end
`ifdef BRANCH_PRED_STATS_EN
        n_cmp++;
        if (br_count !== exp_br || mispred_count !== exp_mis) begin
            n_bad++;
            $display("FAIL stats: got %0d/%0d required %0d/%0d",
                     br_count, mispred_count, exp_br, exp_mis);
        end
`endif
    endtask

    task automatic test_reset_mid_flush();
        int bad_entries;
        drive_mem(1'b1, 1'b0, 1'b1, 1'b0, 32'hC0, 32'h500);
        step();
        idle_mem();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rmf_enter: got busy=%b required 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({flush, busy, redirect_valid} !== 3'b000 || redirect_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL rmf_async: got f/b/rv=%b rpc=%h required 000 00000000",
                     {flush, busy, redirect_valid}, redirect_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bad_entries = 0;
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            if (pred_taken !== 1'b0) bad_entries++;
        end
        n_cmp++;
        if (bad_entries != 0) begin
            n_bad++;
            $display("FAIL rmf_bht: got %0d entries predicting taken required 0", bad_entries);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mispredict_taken();
        test_saturation();
        test_jump();
        test_wrong_path();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
